// File: rtl/gpio_bus_arbiter.sv
// Two-master round-robin arbiter and IDLE->ACCESS->RESP sequencer for the GPIO bus.
// Unmapped or misaligned addresses complete with err_o set and no GPIO strobe.
module gpio_bus_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] GPIO_BASE  = 32'h10010024,
    parameter logic [31:0] GPIO_LAST  = 32'h10010028,
    localparam int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_i,
    input  logic [1:0]            we_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic [1:0]            ack_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  busy_o,
    output logic                  Mem_Read_o,
    output logic                  Mem_Write_o,
    output logic [ADDR_WIDTH-1:0] gpio_addr_o,
    output logic [DATA_WIDTH-1:0] gpio_wdata_o,
    input  logic [DATA_WIDTH-1:0] gpio_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   cmd_id;
    logic   cmd_we;
    logic   cmd_mapped;

    logic                  win_id_c;
    logic                  sel_we_c;
    logic [ADDR_WIDTH-1:0] sel_addr_c;
    logic [DATA_WIDTH-1:0] sel_wdata_c;
    logic                  sel_mapped_c;

    // Winner selection and address decode for the request seen in IDLE
    always_comb begin
        win_id_c = 1'b0;
        case (req_i)
            2'b10:   win_id_c = 1'b1;
            2'b11:   win_id_c = ~last_grant;
            default: win_id_c = 1'b0;
        endcase
        sel_we_c     = we_i[win_id_c];
        sel_addr_c   = win_id_c ? addr1_i : addr0_i;
        sel_wdata_c  = win_id_c ? wdata1_i : wdata0_i;
        sel_mapped_c = (sel_addr_c[1:0] == 2'b00) &&
                       (sel_addr_c >= GPIO_BASE) &&
                       (sel_addr_c <= GPIO_LAST);
    end

    // gpio_addr_o/gpio_wdata_o double as the address/data command registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            last_grant   <= 1'b1;
            cmd_id       <= 1'b0;
            cmd_we       <= 1'b0;
            cmd_mapped   <= 1'b0;
            ack_o        <= 2'b00;
            err_o        <= 1'b0;
            rdata_o      <= '0;
            busy_o       <= 1'b0;
            Mem_Read_o   <= 1'b0;
            Mem_Write_o  <= 1'b0;
            gpio_addr_o  <= '0;
            gpio_wdata_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_i != 2'b00) begin
                        state        <= S_ACCESS;
                        busy_o       <= 1'b1;
                        cmd_id       <= win_id_c;
                        cmd_we       <= sel_we_c;
                        cmd_mapped   <= sel_mapped_c;
                        gpio_addr_o  <= sel_addr_c;
                        gpio_wdata_o <= sel_wdata_c;
                        Mem_Write_o  <= sel_mapped_c & sel_we_c;
                        Mem_Read_o   <= sel_mapped_c & ~sel_we_c;
                    end
                end
                S_ACCESS: begin
                    state        <= S_RESP;
                    Mem_Write_o  <= 1'b0;
                    Mem_Read_o   <= 1'b0;
                    gpio_addr_o  <= '0;
                    gpio_wdata_o <= '0;
                    ack_o        <= cmd_id ? 2'b10 : 2'b01;
                    err_o        <= ~cmd_mapped;
                    rdata_o      <= (cmd_mapped && !cmd_we) ? gpio_rdata_i : '0;
                end
                S_RESP: begin
                    state      <= S_IDLE;
                    busy_o     <= 1'b0;
                    ack_o      <= 2'b00;
                    err_o      <= 1'b0;
                    rdata_o    <= '0;
                    last_grant <= cmd_id;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Scoreboard bench for gpio_bus_arbiter with a small LED/switch GPIO model.
module tb_gpio_bus_arbiter;

    localparam logic [31:0] LED_A = 32'h10010024;
    localparam logic [31:0] SW_A  = 32'h10010028;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_i, we_i;
    logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
    logic [1:0]  ack_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic        busy_o, Mem_Read_o, Mem_Write_o;
    logic [31:0] gpio_addr_o, gpio_wdata_o, gpio_rdata_i;

    logic [31:0] led = '0;
    logic [8:0]  sw;

    typedef struct {
        logic [1:0]  ack;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    resp_t exp_q[$];
    resp_t got_arr[64];
    int    got_wr = 0;
    int    rd = 0;
    int    errors = 0;
    int    checks = 0;
    logic  inv_bad = 1'b0;
    resp_t e, g;
    logic [31:0] led_before;
    int    base;
    logic [31:0] ua [2];
    logic        uw [2];
    logic [1:0]  ack_pat [5];

    always #5 clk = ~clk;

    gpio_bus_arbiter dut (
        .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
        .Mem_Read_o(Mem_Read_o), .Mem_Write_o(Mem_Write_o),
        .gpio_addr_o(gpio_addr_o), .gpio_wdata_o(gpio_wdata_o), .gpio_rdata_i(gpio_rdata_i)
    );

    assign gpio_rdata_i = (gpio_addr_o == SW_A)  ? {23'b0, sw} :
                          (gpio_addr_o == LED_A) ? led : 32'h0;

    always @(posedge clk) if (Mem_Write_o && gpio_addr_o == LED_A) led <= gpio_wdata_o;

    // Response monitor and bus invariants
    always @(negedge clk) begin
        if (ack_o != 2'b00 && got_wr < 64) begin
            got_arr[got_wr] <= '{ack_o, err_o, rdata_o};
            got_wr <= got_wr + 1;
        end
        if (ack_o == 2'b11 || (Mem_Read_o && Mem_Write_o)) inv_bad <= 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic [1:0] a, input logic er, input logic [31:0] d);
        resp_t r;
        r.ack = a; r.err = er; r.rdata = d;
        exp_q.push_back(r);
    endtask

    task automatic test_reset();
        reset = 1'b0; req_i = 2'b11; we_i = 2'b00;
        addr0_i = SW_A; addr1_i = SW_A; wdata0_i = '0; wdata1_i = '0; sw = 9'h155;
        tick(3);
        checks++;
        if ({ack_o, err_o, busy_o, Mem_Read_o, Mem_Write_o} !== 6'b0 || gpio_addr_o !== 0 ||
            gpio_wdata_o !== 0 || rdata_o !== 0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b err=%b busy=%b rd=%b wr=%b addr=%h, required all 0",
                     ack_o, err_o, busy_o, Mem_Read_o, Mem_Write_o, gpio_addr_o);
        end
        expect_resp(2'b01, 1'b0, 32'h155);
        reset = 1'b1;
        tick(1);
        checks++;
        if (busy_o !== 1'b1 || ack_o !== 2'b00 || Mem_Read_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_grant: busy=%b ack=%b rd=%b, required 1 00 1", busy_o, ack_o, Mem_Read_o);
        end
        tick(1);
        checks++;
        if (ack_o !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_ack: ack=%b, required 01", ack_o);
        end
        req_i = 2'b00;
        for (int k = 0; k < 40 && got_wr < rd + 1; k++) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (rd >= got_wr) begin
                errors++; $display("FAIL reset_resp: no ack, required ack=%b", e.ack);
            end else begin
                g = got_arr[rd]; rd++;
                if (g.ack !== e.ack || g.err !== e.err || g.rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL reset_resp: ack=%b err=%b rdata=%h, required %b %b %h",
                             g.ack, g.err, g.rdata, e.ack, e.err, e.rdata);
                end
            end
        end
        tick(2);
    endtask

    task automatic test_write();
        req_i = 2'b01; we_i = 2'b01; addr0_i = LED_A; wdata0_i = 32'h1A5;
        expect_resp(2'b01, 1'b0, 32'h0);
        tick(1);
        checks++;
        if (Mem_Write_o !== 1'b1 || Mem_Read_o !== 1'b0) begin
            errors++; $display("FAIL write_strobes: wr=%b rd=%b, required 1 0", Mem_Write_o, Mem_Read_o);
        end
        checks++;
        if (gpio_addr_o !== LED_A || gpio_wdata_o !== 32'h1A5) begin
            errors++;
            $display("FAIL write_bus: addr=%h data=%h, required %h 000001a5", gpio_addr_o, gpio_wdata_o, LED_A);
        end
        tick(1);
        checks++;
        if (ack_o !== 2'b01 || err_o !== 1'b0) begin
            errors++; $display("FAIL write_ack: ack=%b err=%b, required 01 0", ack_o, err_o);
        end
        req_i = 2'b00;
        for (int k = 0; k < 40 && got_wr < rd + 1; k++) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (rd >= got_wr) begin
                errors++; $display("FAIL write_resp: no ack, required ack=%b", e.ack);
            end else begin
                g = got_arr[rd]; rd++;
                if (g.ack !== e.ack || g.err !== e.err || g.rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL write_resp: ack=%b err=%b rdata=%h, required %b %b %h",
                             g.ack, g.err, g.rdata, e.ack, e.err, e.rdata);
                end
            end
        end
        checks++;
        if (led !== 32'h1A5) begin
            errors++; $display("FAIL write_led: led=%h, required 000001a5", led);
        end
        tick(1);
    endtask

    task automatic test_read();
        sw = 9'h0F3;
        req_i = 2'b10; we_i = 2'b00; addr1_i = SW_A; wdata1_i = 32'hDEADBEEF;
        expect_resp(2'b10, 1'b0, 32'h000000F3);
        tick(1);
        checks++;
        if (Mem_Read_o !== 1'b1 || Mem_Write_o !== 1'b0) begin
            errors++; $display("FAIL read_strobes: rd=%b wr=%b, required 1 0", Mem_Read_o, Mem_Write_o);
        end
        tick(1);
        checks++;
        if (ack_o !== 2'b10 || rdata_o !== 32'h000000F3 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL read_ack: ack=%b rdata=%h err=%b, required 10 000000f3 0", ack_o, rdata_o, err_o);
        end
        req_i = 2'b00;
        for (int k = 0; k < 40 && got_wr < rd + 1; k++) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (rd >= got_wr) begin
                errors++; $display("FAIL read_resp: no ack, required ack=%b", e.ack);
            end else begin
                g = got_arr[rd]; rd++;
                if (g.ack !== e.ack || g.err !== e.err || g.rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL read_resp: ack=%b err=%b rdata=%h, required %b %b %h",
                             g.ack, g.err, g.rdata, e.ack, e.err, e.rdata);
                end
            end
        end
        tick(1);
    endtask

    task automatic test_contention();
        reset = 1'b0;
        tick(1);
        sw = 9'h0F3;
        req_i = 2'b11; we_i = 2'b01;
        addr0_i = LED_A; wdata0_i = 32'h55; addr1_i = SW_A; wdata1_i = '0;
        for (int i = 0; i < 2; i++) begin
            expect_resp(2'b01, 1'b0, 32'h0);
            expect_resp(2'b10, 1'b0, 32'h000000F3);
        end
        reset = 1'b1;
        tick(12);
        req_i = 2'b00;
        for (int k = 0; k < 40 && got_wr < rd + 4; k++) @(posedge clk);
        tick(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (rd >= got_wr) begin
                errors++; $display("FAIL contention_resp: no ack, required ack=%b", e.ack);
            end else begin
                g = got_arr[rd]; rd++;
                if (g.ack !== e.ack || g.err !== e.err || g.rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL contention_resp: ack=%b err=%b rdata=%h, required %b %b %h",
                             g.ack, g.err, g.rdata, e.ack, e.err, e.rdata);
                end
            end
        end
        checks++;
        if (got_wr !== rd) begin
            errors++; $display("FAIL contention_count: extra acks=%0d, required 0", got_wr - rd);
        end
        checks++;
        if (inv_bad !== 1'b0) begin
            errors++; $display("FAIL contention_invariant: flag=%b, required 0", inv_bad);
        end
    endtask

    task automatic test_unmapped();
        sw = 9'h1FF;
        led_before = led;
        ua[0] = 32'h10010030; uw[0] = 1'b0;
        ua[1] = 32'h10010025; uw[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_i = 2'b01; we_i = {1'b0, uw[i]}; addr0_i = ua[i]; wdata0_i = 32'hDEAD;
            expect_resp(2'b01, 1'b1, 32'h0);
            tick(1);
            checks++;
            if (Mem_Read_o !== 1'b0 || Mem_Write_o !== 1'b0 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL unmapped_strobes[%0d]: rd=%b wr=%b busy=%b, required 0 0 1",
                         i, Mem_Read_o, Mem_Write_o, busy_o);
            end
            tick(1);
            checks++;
            if (ack_o !== 2'b01 || err_o !== 1'b1 || rdata_o !== 32'h0) begin
                errors++;
                $display("FAIL unmapped_ack[%0d]: ack=%b err=%b rdata=%h, required 01 1 0",
                         i, ack_o, err_o, rdata_o);
            end
            req_i = 2'b00;
            tick(1);
        end
        for (int k = 0; k < 40 && got_wr < rd + 2; k++) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (rd >= got_wr) begin
                errors++; $display("FAIL unmapped_resp: no ack, required ack=%b", e.ack);
            end else begin
                g = got_arr[rd]; rd++;
                if (g.ack !== e.ack || g.err !== e.err || g.rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL unmapped_resp: ack=%b err=%b rdata=%h, required %b %b %h",
                             g.ack, g.err, g.rdata, e.ack, e.err, e.rdata);
                end
            end
        end
        checks++;
        if (led !== led_before) begin
            errors++; $display("FAIL unmapped_led: led=%h, required %h", led, led_before);
        end
    endtask

    task automatic test_back_to_back();
        req_i = 2'b01; we_i = 2'b01; addr0_i = LED_A; wdata0_i = 32'h0AA;
        expect_resp(2'b01, 1'b0, 32'h0);
        tick(1);
        req_i = 2'b00; wdata0_i = 32'h777; addr0_i = 32'h0;
        checks++;
        if (gpio_wdata_o !== 32'h0AA || gpio_addr_o !== LED_A || Mem_Write_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold: data=%h addr=%h wr=%b, required 000000aa %h 1",
                     gpio_wdata_o, gpio_addr_o, Mem_Write_o, LED_A);
        end
        tick(1);
        checks++;
        if (ack_o !== 2'b01) begin
            errors++; $display("FAIL b2b_drop_ack: ack=%b, required 01", ack_o);
        end
        tick(1);
        sw = 9'h0C3;
        req_i = 2'b10; we_i = 2'b00; addr1_i = SW_A;
        expect_resp(2'b10, 1'b0, 32'h000000C3);
        expect_resp(2'b10, 1'b0, 32'h000000C3);
        ack_pat[0] = 2'b00; ack_pat[1] = 2'b10; ack_pat[2] = 2'b00;
        ack_pat[3] = 2'b00; ack_pat[4] = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checks++;
            if (ack_o !== ack_pat[i]) begin
                errors++; $display("FAIL b2b_seq[%0d]: ack=%b, required %b", i, ack_o, ack_pat[i]);
            end
        end
        req_i = 2'b00;
        for (int k = 0; k < 40 && got_wr < rd + 3; k++) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (rd >= got_wr) begin
                errors++; $display("FAIL b2b_resp: no ack, required ack=%b", e.ack);
            end else begin
                g = got_arr[rd]; rd++;
                if (g.ack !== e.ack || g.err !== e.err || g.rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL b2b_resp: ack=%b err=%b rdata=%h, required %b %b %h",
                             g.ack, g.err, g.rdata, e.ack, e.err, e.rdata);
                end
            end
        end
        checks++;
        if (led !== 32'h0AA) begin
            errors++; $display("FAIL b2b_led: led=%h, required 000000aa", led);
        end
        tick(2);
    endtask

    task automatic test_reset_mid();
        led_before = led;
        base = got_wr;
        req_i = 2'b01; we_i = 2'b01; addr0_i = LED_A; wdata0_i = 32'h3C;
        tick(1);
        checks++;
        if (Mem_Write_o !== 1'b1) begin
            errors++; $display("FAIL midrst_access: wr=%b, required 1", Mem_Write_o);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (Mem_Write_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL midrst_async: wr=%b busy=%b, required 0 0", Mem_Write_o, busy_o);
        end
        req_i = 2'b00;
        tick(2);
        reset = 1'b1;
        tick(4);
        checks++;
        if (got_wr !== base) begin
            errors++; $display("FAIL midrst_noack: acks=%0d, required 0", got_wr - base);
        end
        checks++;
        if (led !== led_before) begin
            errors++; $display("FAIL midrst_led: led=%h, required %h", led, led_before);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (inv_bad !== 1'b0) begin
            errors++; $display("FAIL final_invariant: flag=%b, required 0", inv_bad);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
